// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, two combinational read ports, optional
// write forwarding and hardwired-zero R0, plus a per-register busy scoreboard.
module regfile_mp #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int BYPASS  = 0,
  parameter int ZERO_R0 = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [ADDR_W-1:0]      writenum,
  input  logic                   write,
  input  logic [ADDR_W-1:0]      readnum_a,
  input  logic [ADDR_W-1:0]      readnum_b,
  output logic [DATA_W-1:0]      data_out_a,
  output logic [DATA_W-1:0]      data_out_b,
  input  logic                   reserve,
  input  logic [ADDR_W-1:0]      reservenum,
  output logic                   busy_a,
  output logic                   busy_b,
  output logic [(2**ADDR_W)-1:0] busy_vec
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [NREGS-1:0]  wr_sel;
  logic [NREGS-1:0]  rsv_sel;

  // Per-register decode; a hardwired R0 simply never gets selected.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    localparam bit LOCKED = (ZERO_R0 != 0) && (gi == 0);
    assign wr_sel[gi]  = !LOCKED && write   && (writenum   == ADDR_W'(gi));
    assign rsv_sel[gi] = !LOCKED && reserve && (reservenum == ADDR_W'(gi));
    // A reserve landing with the completing write leaves the register busy.
    assign busy_d[gi]  = rsv_sel[gi] | (busy_q[gi] & ~wr_sel[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_sel[i]) regs_q[i] <= data_in;
      end
      busy_q <= busy_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [ADDR_W-1:0] sel;
    logic [DATA_W-1:0] data_c;
    logic              busy_c;

    assign sel = (gi == 0) ? readnum_a : readnum_b;

    always_comb begin
      data_c = regs_q[sel];
      busy_c = busy_q[sel];
      if ((BYPASS != 0) && write && (writenum == sel)) begin
        data_c = data_in;
        busy_c = reserve && (reservenum == sel);
      end
      if ((ZERO_R0 != 0) && (sel == '0)) begin
        data_c = '0;
        busy_c = 1'b0;
      end
      // Reset masks the forwarded path too, not just the cleared storage.
      if (!rst_n) begin
        data_c = '0;
        busy_c = 1'b0;
      end
    end
  end

  assign data_out_a = g_rd[0].data_c;
  assign data_out_b = g_rd[1].data_c;
  assign busy_a     = g_rd[0].busy_c;
  assign busy_b     = g_rd[1].busy_c;
  assign busy_vec   = rst_n ? busy_q : '0;

endmodule
